// File: rtl/dram_miss_engine_if.sv
// +----------------------------------------------------------------------------+
// | dram_miss_engine_if : shared LSU opcode package and miss-engine bus.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package cache_pkg;
  typedef enum logic {LW = 1'b0, SW = 1'b1} lsu_ops;
endpackage

interface dram_miss_engine_if #(
  parameter int TAG  = 22,
  parameter int DATA = 32
);
  // Cache-controller side
  logic              miss_req;
  logic              miss_ready;
  logic [31:0]       miss_addr;
  logic              victim_dirty;
  logic [31:0]       victim_addr;
  logic [TAG-1:0]    victim_tag;
  logic [DATA-1:0]   victim_data;
  logic              refill_valid;
  logic [DATA-1:0]   refill_data;
  logic              refill_err;
  // DRAM side
  logic              mem_req;
  cache_pkg::lsu_ops lsu_operator;
  logic [31:0]       mem_addr;
  logic [TAG+DATA:0] mem_wdata;
  logic              mem_ready;
  logic [DATA-1:0]   mem_rdata;

  modport master (
    input  miss_req, miss_addr, victim_dirty, victim_addr, victim_tag, victim_data,
    input  mem_ready, mem_rdata,
    output miss_ready, refill_valid, refill_data, refill_err,
    output mem_req, lsu_operator, mem_addr, mem_wdata
  );

  modport slave (
    output miss_req, miss_addr, victim_dirty, victim_addr, victim_tag, victim_data,
    output mem_ready, mem_rdata,
    input  miss_ready, refill_valid, refill_data, refill_err,
    input  mem_req, lsu_operator, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dram_miss_engine.sv
// +----------------------------------------------------------------------------+
// | dram_miss_engine : victim write-back then line fetch on a data-cache miss. |
// | Optional macro MEM_TIMEOUT_EN adds an unacknowledged-request timeout.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module dram_miss_engine #(
  parameter int TAG            = 22,
  parameter int DATA           = 32,
  parameter int RD_LAT         = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic            clk,
  input  wire logic            rst,
  dram_miss_engine_if.master   bus,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] miss_addr_q;
  logic [3:0]  lat_cnt;
  logic        timeout;

  assign bus.miss_ready   = (state == IDLE);
  assign bus.refill_valid = (state == RESP);

`ifdef MEM_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        waiting;
  logic        err_q;

  assign waiting = ((state == WB_REQ) || (state == RD_REQ)) && !bus.mem_ready;
  assign timeout = waiting && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Count restarts at every state change so each request gets a full budget
  always_ff @(posedge clk) begin
    if (rst || (state != state_nxt)) begin
      wait_cnt <= 16'd0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && bus.miss_req) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign bus.refill_err = err_q;
`else
  assign timeout        = 1'b0;
  assign bus.refill_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.miss_req) begin
          state_nxt = bus.victim_dirty ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        if (timeout) begin
          state_nxt = RESP;
        end else if (bus.mem_ready) begin
          state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        if (timeout) begin
          state_nxt = RESP;
        end else if (bus.mem_ready) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are loaded one edge ahead of the request state, so they
  // are already stable in the first cycle mem_req is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_addr_q      <= 32'd0;
      lat_cnt          <= 4'd0;
      bus.mem_req      <= 1'b0;
      bus.lsu_operator <= cache_pkg::LW;
      bus.mem_addr     <= 32'd0;
      bus.mem_wdata    <= '0;
      bus.refill_data  <= '0;
      rd_count         <= 16'd0;
      wr_count         <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_req) begin
            miss_addr_q <= bus.miss_addr;
            bus.mem_req <= 1'b1;
            if (bus.victim_dirty) begin
              bus.lsu_operator <= cache_pkg::SW;
              bus.mem_addr     <= bus.victim_addr;
              bus.mem_wdata    <= {1'b1, bus.victim_tag, bus.victim_data};
            end else begin
              bus.lsu_operator <= cache_pkg::LW;
              bus.mem_addr     <= bus.miss_addr;
            end
          end
        end
        WB_REQ: begin
          if (timeout) begin
            bus.mem_req     <= 1'b0;
            bus.refill_data <= '0;
          end else if (bus.mem_ready) begin
            wr_count         <= wr_count + 16'd1;
            bus.lsu_operator <= cache_pkg::LW;
            bus.mem_addr     <= miss_addr_q;
          end
        end
        RD_REQ: begin
          if (timeout) begin
            bus.mem_req     <= 1'b0;
            bus.refill_data <= '0;
          end else if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            lat_cnt     <= 4'(RD_LAT);
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 4'd1) begin
            bus.refill_data <= bus.mem_rdata;
            rd_count        <= rd_count + 16'd1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_miss_engine.sv
// +----------------------------------------------------------------------------+
// | tb_dram_miss_engine : directed self-checking bench with a transaction model|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dram_miss_engine;
  import cache_pkg::*;

  localparam int TAG    = 22;
  localparam int DATA   = 32;
  localparam int RD_LAT = 1;
  localparam int TO     = 8;

  logic        clk;
  logic        rst;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        hold;
  int          cyc;
  int          checks;
  int          errors;

  dram_miss_engine_if #(.TAG(TAG), .DATA(DATA)) bus ();

  dram_miss_engine #(
    .TAG(TAG), .DATA(DATA), .RD_LAT(RD_LAT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_count(rd_count), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DRAM: word memory; LW data is presented exactly RD_LAT cycles after acceptance
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] pend_data;
  int          pend_cnt;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  always_comb bus.mem_ready = (bus.mem_req === 1'b1) && !hold;
  always_comb bus.mem_rdata = (pend_cnt == 1) ? pend_data : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (bus.mem_req === 1'b1 && bus.mem_ready && bus.lsu_operator == LW) begin
      pend_data <= rd_mem(bus.mem_addr);
      pend_cnt  <= RD_LAT;
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  // Transaction model: an accepted miss queues its DRAM requests; requests are
  // issued back-to-back; a refill follows each accepted LW by RD_LAT+1 cycles.
  typedef struct {
    lsu_ops      op;
    logic [31:0] addr;
    logic [54:0] wdata;
  } req_t;

  req_t        q[$];
  req_t        r;
  bit          busy;
  bit          due;
  int          refill_due;
  int          head_wait;
  logic [31:0] exp_data;
  logic        exp_err;
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      busy = 0; q.delete(); refill_due = -1; head_wait = 0;
      exp_rd = 16'd0; exp_wr = 16'd0; exp_err = 1'b0;
    end else begin
      due = (refill_due == cyc);
      if (due && !exp_err) exp_rd = exp_rd + 16'd1;
      chk("miss_ready", bus.miss_ready, !busy);
      chk("refill_valid", bus.refill_valid, due);
      if (due) begin
        chk("refill_data", bus.refill_data, exp_data);
        chk("refill_err", bus.refill_err, exp_err);
      end
      chk("mem_req", bus.mem_req, q.size() != 0);
      if (q.size() != 0 && bus.mem_req === 1'b1) begin
        chk("lsu_operator", bus.lsu_operator, q[0].op);
        chk("mem_addr", bus.mem_addr, q[0].addr);
        if (q[0].op == SW) chk("mem_wdata", bus.mem_wdata, q[0].wdata);
      end
      chk("rd_count", rd_count, exp_rd);
      chk("wr_count", wr_count, exp_wr);

      if (q.size() != 0) begin
        if (bus.mem_ready === 1'b1) begin
          r = q.pop_front();
          head_wait = 0;
          if (r.op == SW) begin
            mem_model[r.addr] = r.wdata[31:0];
            exp_wr = exp_wr + 16'd1;
          end else begin
            refill_due = cyc + RD_LAT + 1;
            exp_data   = rd_mem(r.addr);
            exp_err    = 1'b0;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (head_wait == TO - 1) begin
          q.delete();
          head_wait  = 0;
          refill_due = cyc + 1;
          exp_data   = 32'h0;
          exp_err    = 1'b1;
        end else begin
          head_wait++;
        end
`endif
      end
      if (!busy && bus.miss_req === 1'b1) begin
        busy = 1;
        head_wait = 0;
        if (bus.victim_dirty)
          q.push_back('{SW, bus.victim_addr, {1'b1, bus.victim_tag, bus.victim_data}});
        q.push_back('{LW, bus.miss_addr, 55'h0});
      end
      if (due) begin
        busy = 0;
        refill_due = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_miss(input logic [31:0] a, input logic d, input logic [31:0] va,
                           input logic [21:0] vt, input logic [31:0] vd, output int acc);
    tick();
    for (int i = 0; i < 30 && bus.miss_ready !== 1'b1; i++) tick();
    if (bus.miss_ready !== 1'b1) chk("idle_wait", bus.miss_ready, 1'b1);
    bus.miss_addr = a; bus.victim_dirty = d; bus.victim_addr = va;
    bus.victim_tag = vt; bus.victim_data = vd; bus.miss_req = 1'b1;
    acc = cyc;
    tick();
    bus.miss_req = 1'b0;
  endtask

  task automatic wait_refill(output int rc);
    rc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.refill_valid === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) chk("refill_wait", 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, n;
    checks = 0; errors = 0; hold = 1'b0; rst = 1'b1;
    bus.miss_req = 1'b0; bus.miss_addr = 32'h0; bus.victim_dirty = 1'b0;
    bus.victim_addr = 32'h0; bus.victim_tag = '0; bus.victim_data = '0;
    mem_model[32'h10] = 32'hDEAD0010;
    mem_model[32'h30] = 32'hCAFE0030;
    mem_model[32'h40] = 32'h40404040;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miss_ready", bus.miss_ready, 1'b1);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 55'h0);
    chk("rst_lsu_op", bus.lsu_operator, LW);
    chk("rst_refill_data", bus.refill_data, 32'h0);

    // Clean miss
    send_miss(32'h10, 1'b0, 32'h0, 22'h0, 32'h0, acc);
    wait_refill(rc);
    chk("clean_latency", rc - acc, 3);
    chk("clean_data", bus.refill_data, 32'hDEAD0010);
    chk("clean_rd_count", rd_count, 16'd1);
    chk("clean_wr_count", wr_count, 16'd0);

    // Dirty miss: write-back of 0x20 then fetch of 0x30
    send_miss(32'h30, 1'b1, 32'h20, 22'h2ABCD, 32'h12345678, acc);
    chk("dirty_wdata", bus.mem_wdata, {1'b1, 22'h2ABCD, 32'h12345678});
    chk("dirty_op", bus.lsu_operator, SW);
    chk("dirty_addr", bus.mem_addr, 32'h20);
    wait_refill(rc);
    chk("dirty_latency", rc - acc, 4);
    chk("dirty_data", bus.refill_data, 32'hCAFE0030);
    chk("dirty_wr_count", wr_count, 16'd1);
    send_miss(32'h20, 1'b0, 32'h0, 22'h0, 32'h0, acc);
    wait_refill(rc);
    chk("wb_readback", bus.refill_data, 32'h12345678);

    // Back-pressure: DRAM refuses the read for 5 cycles
    hold = 1'b1;
    send_miss(32'h40, 1'b0, 32'h0, 22'h0, 32'h0, acc);
    repeat (5) tick();
    hold = 1'b0;
    wait_refill(rc);
    chk("bp_latency", rc - acc, 8);
    chk("bp_data", bus.refill_data, 32'h40404040);

    // Busy rejection: miss_req held for 10 cycles
    tick();
    bus.miss_addr = 32'h10; bus.victim_dirty = 1'b0; bus.miss_req = 1'b1;
    n = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 10) bus.miss_req = 1'b0;
      @(negedge clk);
      if (bus.refill_valid === 1'b1) n++;
      tick();
    end
    chk("busy_refills", n, 3);
    chk("busy_rd_count", rd_count, 16'd7);

    // Reset while waiting for read data
    send_miss(32'h10, 1'b0, 32'h0, 22'h0, 32'h0, acc);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_mem_req", bus.mem_req, 1'b0);
    chk("rstw_refill_valid", bus.refill_valid, 1'b0);
    chk("rstw_rd_count", rd_count, 16'd0);
    chk("rstw_wr_count", wr_count, 16'd0);
    send_miss(32'h10, 1'b0, 32'h0, 22'h0, 32'h0, acc);
    wait_refill(rc);
    chk("rstw_latency", rc - acc, 3);
    chk("rstw_data", bus.refill_data, 32'hDEAD0010);

`ifdef MEM_TIMEOUT_EN
    // DRAM never answers: request abandoned after TO cycles
    hold = 1'b1;
    send_miss(32'h30, 1'b1, 32'h60, 22'h1, 32'h55, acc);
    n = 0;
    rc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) n++;
      if (bus.refill_valid === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    chk("to_req_cycles", n, TO);
    chk("to_refill_seen", rc >= 0, 1'b1);
    chk("to_err", bus.refill_err, 1'b1);
    chk("to_data", bus.refill_data, 32'h0);
    chk("to_rd_count", rd_count, 16'd1);
    chk("to_wr_count", wr_count, 16'd0);
    hold = 1'b0;
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dram_miss_engine.md
Name: dram_miss_engine

Overview:
- Memory-side initiator for the data cache: on a cache miss it optionally writes back the dirty victim line, then fetches the missing line from DRAM.
- Drives the DRAM request interface (mem_req / lsu_operator / address / write data) and returns the refill word to the cache controller.
- Sits between the cache controller and the DRAM model. Uses lsu_ops (LW/SW) from cache_pkg.

Parameters:
- TAG, 22, victim tag width carried in write-back data
- DATA, 32, line/word data width
- RD_LAT, 1, cycles from accepted LW (mem_req & mem_ready) to valid mem_rdata; legal 1..15
- TIMEOUT_CYCLES, 64, unacknowledged-request limit (used only with MEM_TIMEOUT_EN)

Ports:
- clk input 1: clock
- rst input 1: reset, synchronous, active-high
- miss_req input 1: cache requests miss service
- miss_ready output 1: engine idle, accepts miss_req
- miss_addr input 32: address of missing line
- victim_dirty input 1: victim needs write-back
- victim_addr input 32: victim line address
- victim_tag input TAG: victim tag
- victim_data input DATA: victim data
- refill_valid output 1: one-cycle pulse, refill_data valid
- refill_data output DATA: fetched line data
- refill_err output 1: valid with refill_valid; request timed out
- mem_req output 1: DRAM request
- lsu_operator output lsu_ops: LW or SW
- mem_addr output 32: DRAM address
- mem_wdata output TAG+DATA+1: {1'b1, victim_tag, victim_data}
- mem_ready input 1: DRAM accepts request this cycle
- mem_rdata input DATA: DRAM read data
- rd_count output 16: completed LW transactions, wraps
- wr_count output 16: completed SW transactions, wraps

Behaviour:
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT, RESP.
- Reset values: state IDLE; mem_req=0, lsu_operator=LW, mem_addr=0, mem_wdata=0, refill_valid=0, refill_data=0, refill_err=0, rd_count=0, wr_count=0. miss_ready=1 the cycle after reset.
- miss_ready = (state==IDLE), combinational.
- IDLE: if miss_req, latch all miss_*/victim_* inputs.
  - victim_dirty=1 -> WB_REQ; otherwise -> RD_REQ.
  - Inputs are ignored while miss_ready=0.
- WB_REQ:
  - Outputs: mem_req=1, lsu_operator=SW, mem_addr=latched victim_addr, mem_wdata per port definition.
  - On a clk edge with mem_ready=1: wr_count++, -> RD_REQ.
- RD_REQ:
  - Outputs: mem_req=1, lsu_operator=LW, mem_addr=latched miss_addr.
  - On mem_ready=1: load the latency counter with RD_LAT, -> RD_WAIT.
- RD_WAIT:
  - Outputs: mem_req=0; counter decrements each cycle.
  - In the cycle the counter reads 1: capture mem_rdata into refill_data, rd_count++, -> RESP.
- RESP: refill_valid=1 for exactly one cycle, then -> IDLE.
- Request stability: mem_addr, lsu_operator and mem_wdata stay stable while mem_req=1 and mem_ready=0. No new request is issued until the previous one is accepted.
- Latency, mem_ready tied high, RD_LAT=1:
  - Clean miss: accept at edge 0, RD_REQ cycle 1, RD_WAIT cycle 2, refill_valid cycle 3.
  - Dirty miss: one cycle later.
- SW completes on acceptance; no write response is expected.
- Counters: rd_count and wr_count wrap 0xFFFF -> 0x0000.
- Reset mid-operation:
  - The next edge forces IDLE, clears mem_req and drops the in-flight transaction.
  - No refill_valid is produced; counters clear.
- miss_req asserted in the same cycle as RESP is not accepted; it is accepted the following cycle (IDLE).

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A 16-bit wait counter increments each cycle in WB_REQ/RD_REQ with mem_ready=0, and clears on state entry.
  - At count == TIMEOUT_CYCLES-1 with mem_ready still 0: deassert mem_req, -> RESP with refill_err=1 and refill_data=0.
  - Neither counter increments for the timed-out transaction, and a pending read is skipped.
- MEM_TIMEOUT_EN undefined:
  - The engine waits indefinitely for mem_ready.
  - refill_err is tied 0; the port remains.

Test Plan:
- Clean miss: miss_addr=0x10, victim_dirty=0, mem_ready=mem_req, DRAM returns 0xDEAD0010 -> one LW at address 0x10, refill_valid in cycle 3 with refill_data=0xDEAD0010, rd_count=1, wr_count=0.
- Dirty miss: victim_addr=0x20, victim_data=0x12345678, miss_addr=0x30 -> SW at 0x20 with mem_wdata[31:0]=0x12345678, then LW at 0x30. A later read of 0x20 returns 0x12345678; wr_count=1.
- Back-pressure: mem_ready held 0 for 5 cycles during RD_REQ -> mem_req/mem_addr/lsu_operator stable throughout, completion delayed by exactly 5 cycles.
- Busy rejection: miss_req held high for 10 cycles -> exactly one transaction per IDLE visit; miss_ready=0 from WB_REQ/RD_REQ through RESP.
- Reset during RD_WAIT: rst pulse -> mem_req=0, no refill_valid, rd_count=0; a new clean miss then completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready=0 -> mem_req high for 8 cycles, then refill_valid=1, refill_err=1, refill_data=0, counters unchanged.
